// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: payload layout, reset constants and a packing helper.
package pipe_pkg;

  localparam int unsigned PIPE_DATA_W = 96;

  // Payload layout, LSB first: PC4, PC, INSTR.
  localparam int unsigned PC4_LSB   = 0;
  localparam int unsigned PC4_W     = 32;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned INSTR_LSB = 64;
  localparam int unsigned INSTR_W   = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [PC_W-1:0]    RESET_PC  = 32'h0000_0000;

  function automatic logic [PIPE_DATA_W-1:0] pack_payload(
    input logic [INSTR_W-1:0] instr,
    input logic [PC_W-1:0]    pc,
    input logic [PC4_W-1:0]   pc4
  );
    return {instr, pc, pc4};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register with a 2-entry (main + skid) buffer and flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W         = PIPE_DATA_W,
  parameter bit          CLEAR_ON_FLUSH = 1'b1
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int unsigned CNT_W          = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              accept, drain;

  // in_ready comes straight from a flop: the skid entry absorbs the beat that
  // arrives in the cycle downstream first stalls.
  assign in_ready  = ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign accept    = in_valid & in_ready;
  assign drain     = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      if (CLEAR_ON_FLUSH) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (m_valid_q & ~out_ready),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_bubble_cnt (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (~m_valid_q & out_ready),
    .cnt_o  (bubble_cnt)
  );
`endif

endmodule
